// File: rtl/atm_pkg.sv
// Shared encodings, payload type and defaults for the ATM session front end.
package atm_pkg;

   localparam int unsigned ACC_W       = 16;
   localparam int unsigned AMT_W       = 10;
   localparam int unsigned ACC_NEXT_W  = 17;
   localparam int unsigned OPT_W       = 2;
   localparam int unsigned STATUS_W    = 2;
   localparam int unsigned KEY_W       = 4;
   localparam int unsigned CNT_W       = 3;

   localparam int unsigned DEF_ACC_DIGITS  = 4;
   localparam int unsigned DEF_AMT_MAX     = 1023;
   localparam int unsigned DEF_TIMEOUT_CYC = 1000;

   localparam logic [KEY_W-1:0] KEY_ENTER  = 4'hA;
   localparam logic [KEY_W-1:0] KEY_CANCEL = 4'hB;
   localparam logic [KEY_W-1:0] KEY_CLEAR  = 4'hC;

   localparam logic [OPT_W-1:0] OPT_NONE = 2'b00;
   localparam logic [OPT_W-1:0] OPT_BAL  = 2'b01;
   localparam logic [OPT_W-1:0] OPT_WD   = 2'b10;
   localparam logic [OPT_W-1:0] OPT_TR   = 2'b11;

   localparam logic [STATUS_W-1:0] ST_IDLE = 2'b00;
   localparam logic [STATUS_W-1:0] ST_BUSY = 2'b01;
   localparam logic [STATUS_W-1:0] ST_OK   = 2'b10;
   localparam logic [STATUS_W-1:0] ST_ERR  = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE,
      S_GET_ACC,
      S_GET_OPT,
      S_GET_DST,
      S_GET_AMT,
      S_ISSUE,
      S_WAIT_RSP,
      S_SHOW
   } state_t;

   typedef struct packed {
      logic [OPT_W-1:0] opt;
      logic [ACC_W-1:0] account;
      logic [ACC_W-1:0] dest;
      logic [AMT_W-1:0] amount;
   } req_t;

   function automatic logic is_digit(input logic [KEY_W-1:0] k);
      return k <= 4'd9;
   endfunction

endpackage

// File: rtl/dec_accum.sv
// Decimal key accumulator: value = value*10 + digit with a digit-count limit
// for account fields or a value limit for the amount field.
module dec_accum
   import atm_pkg::*;
#(
   parameter int unsigned ACC_DIGITS = DEF_ACC_DIGITS,
   parameter int unsigned AMT_MAX    = DEF_AMT_MAX
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             digit_en,
   input  logic [KEY_W-1:0] digit,
   input  logic             amt_mode,
   output logic [ACC_W-1:0] value,
   output logic [CNT_W-1:0] count,
   output logic             accept_c
);

   localparam logic [CNT_W-1:0] CNT_SAT = '1;

   logic [ACC_NEXT_W-1:0] next_val;

   assign next_val = ACC_NEXT_W'(value) * ACC_NEXT_W'(10) + ACC_NEXT_W'(digit);

   // Leading zeros in the amount field still count as entered digits, so
   // the counter saturates instead of wrapping.
   assign accept_c = amt_mode ? (next_val <= ACC_NEXT_W'(AMT_MAX))
                              : (32'(count) < ACC_DIGITS);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         value <= '0;
         count <= '0;
      end else if (digit_en && accept_c) begin
         value <= ACC_W'(next_val);
         if (count != CNT_SAT) count <= count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/atm_session_ctrl.sv
// ATM customer session controller: keypad field entry, one request to the
// bank core over valid/ready, response/timeout handling and result display.
module atm_session_ctrl
   import atm_pkg::*;
#(
   parameter int unsigned ACC_DIGITS  = DEF_ACC_DIGITS,
   parameter int unsigned AMT_MAX     = DEF_AMT_MAX,
   parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                key_valid,
   input  logic [KEY_W-1:0]    key_code,
   output logic                req_valid,
   input  logic                req_ready,
   output logic [OPT_W-1:0]    req_opt,
   output logic [ACC_W-1:0]    req_account,
   output logic [ACC_W-1:0]    req_dest,
   output logic [AMT_W-1:0]    req_amount,
   input  logic                rsp_valid,
   input  logic                rsp_error,
   input  logic [AMT_W-1:0]    rsp_balance,
   output logic [AMT_W-1:0]    disp_balance,
   output logic [STATUS_W-1:0] status,
   output logic                key_err
);

   localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);

   state_t                state_q, state_d;
   req_t                  req_q;
   logic                  req_valid_q;
   logic [AMT_W-1:0]      disp_q;
   logic [STATUS_W-1:0]   status_q, status_d;
   logic                  key_err_q;
   logic [TMO_W-1:0]      tmo_cnt_q;

   logic [ACC_W-1:0]      acc_value;
   logic [CNT_W-1:0]      acc_count;
   logic                  acc_accept_c;

   logic                  k_dig_c, k_ent_c, k_can_c, k_clr_c, k_ill_c;
   logic                  tmo_exp_c, has_digits_c, in_field_c;
   logic                  acc_clr_c, acc_dig_c, acc_amt_c;
   logic                  key_err_c, fld_clr_c, opt_ld_c, disp_ld_c;
   logic                  st_acc_c, st_dst_c, st_amt_c;
   logic [OPT_W-1:0]      opt_c;

   assign k_dig_c      = key_valid && is_digit(key_code);
   assign k_ent_c      = key_valid && (key_code == KEY_ENTER);
   assign k_can_c      = key_valid && (key_code == KEY_CANCEL);
   assign k_clr_c      = key_valid && (key_code == KEY_CLEAR);
   assign k_ill_c      = key_valid && (key_code > KEY_CLEAR);
   assign tmo_exp_c    = (tmo_cnt_q == TMO_W'(TIMEOUT_CYC - 1));
   assign has_digits_c = (acc_count != '0);
   assign in_field_c   = (state_q == S_GET_ACC) || (state_q == S_GET_DST) ||
                         (state_q == S_GET_AMT);

   dec_accum #(
      .ACC_DIGITS (ACC_DIGITS),
      .AMT_MAX    (AMT_MAX)
   ) u_dec_accum (
      .clk      (clk),
      .rst      (rst),
      .clr      (acc_clr_c),
      .digit_en (acc_dig_c),
      .digit    (key_code),
      .amt_mode (acc_amt_c),
      .value    (acc_value),
      .count    (acc_count),
      .accept_c (acc_accept_c)
   );

   // State register
   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:    if (k_dig_c) state_d = S_GET_ACC;
         S_GET_ACC,
         S_GET_DST,
         S_GET_AMT: begin
            if (k_can_c) state_d = S_IDLE;
            else if (k_ent_c && has_digits_c) begin
               if (state_q == S_GET_ACC)      state_d = S_GET_OPT;
               else if (state_q == S_GET_DST) state_d = S_GET_AMT;
               else                           state_d = S_ISSUE;
            end
         end
         S_GET_OPT: begin
            if (k_can_c) state_d = S_IDLE;
            else if (k_dig_c) begin
               case (key_code)
                  4'd1:    state_d = S_ISSUE;
                  4'd2:    state_d = S_GET_AMT;
                  4'd3:    state_d = S_GET_DST;
                  default: state_d = S_GET_OPT;
               endcase
            end
         end
         S_ISSUE:    if (req_valid_q && req_ready) state_d = S_WAIT_RSP;
         S_WAIT_RSP: if (rsp_valid || tmo_exp_c) state_d = S_SHOW;
         S_SHOW:     if (key_valid) state_d = S_IDLE;
         default:    state_d = S_IDLE;
      endcase
   end

   // Output / datapath control logic
   always_comb begin
      acc_clr_c = 1'b0;
      acc_dig_c = 1'b0;
      acc_amt_c = (state_q == S_GET_AMT);
      key_err_c = 1'b0;
      fld_clr_c = 1'b0;
      st_acc_c  = 1'b0;
      st_dst_c  = 1'b0;
      st_amt_c  = 1'b0;
      opt_ld_c  = 1'b0;
      opt_c     = OPT_NONE;
      disp_ld_c = 1'b0;
      status_d  = ST_IDLE;

      if (state_q == S_IDLE) begin
         acc_dig_c = k_dig_c;
      end else if (in_field_c) begin
         if (k_dig_c) begin
            acc_dig_c = acc_accept_c;
            key_err_c = !acc_accept_c;
         end else if (k_ent_c) begin
            key_err_c = !has_digits_c;
            acc_clr_c = has_digits_c;
            st_acc_c  = has_digits_c && (state_q == S_GET_ACC);
            st_dst_c  = has_digits_c && (state_q == S_GET_DST);
            st_amt_c  = has_digits_c && (state_q == S_GET_AMT);
         end else if (k_clr_c) begin
            acc_clr_c = 1'b1;
         end else if (k_can_c) begin
            acc_clr_c = 1'b1;
            fld_clr_c = 1'b1;
         end else if (k_ill_c) begin
            key_err_c = 1'b1;
         end
      end else if (state_q == S_GET_OPT) begin
         if (k_dig_c) begin
            case (key_code)
               4'd1:    begin opt_ld_c = 1'b1; opt_c = OPT_BAL; end
               4'd2:    begin opt_ld_c = 1'b1; opt_c = OPT_WD;  end
               4'd3:    begin opt_ld_c = 1'b1; opt_c = OPT_TR;  end
               default: key_err_c = 1'b1;
            endcase
         end else if (k_can_c) begin
            acc_clr_c = 1'b1;
            fld_clr_c = 1'b1;
         end else if (k_ill_c) begin
            key_err_c = 1'b1;
         end
      end else if (state_q == S_WAIT_RSP) begin
         disp_ld_c = rsp_valid && !rsp_error && (req_q.opt == OPT_BAL);
      end else if (state_q == S_SHOW) begin
         if (key_valid) begin
            acc_clr_c = 1'b1;
            fld_clr_c = 1'b1;
         end
      end

      // A response in the expiry cycle takes precedence over the timeout.
      case (state_d)
         S_ISSUE, S_WAIT_RSP: status_d = ST_BUSY;
         S_SHOW: begin
            if (state_q == S_WAIT_RSP)
               status_d = (rsp_valid && !rsp_error) ? ST_OK : ST_ERR;
            else
               status_d = status_q;
         end
         default: status_d = ST_IDLE;
      endcase
   end

   // Registered outputs and session fields
   always_ff @(posedge clk) begin
      if (rst) begin
         req_q       <= '0;
         req_valid_q <= 1'b0;
         disp_q      <= '0;
         status_q    <= ST_IDLE;
         key_err_q   <= 1'b0;
         tmo_cnt_q   <= '0;
      end else begin
         req_valid_q <= (state_d == S_ISSUE);
         status_q    <= status_d;
         key_err_q   <= key_err_c;
         tmo_cnt_q   <= (state_q == S_WAIT_RSP) ? tmo_cnt_q + TMO_W'(1) : '0;
         if (disp_ld_c) disp_q <= rsp_balance;
         if (fld_clr_c) begin
            req_q <= '0;
         end else begin
            if (st_acc_c) req_q.account <= acc_value;
            if (st_dst_c) req_q.dest    <= acc_value;
            if (st_amt_c) req_q.amount  <= AMT_W'(acc_value);
            if (opt_ld_c) req_q.opt     <= opt_c;
         end
      end
   end

   assign req_valid    = req_valid_q;
   assign req_opt      = req_q.opt;
   assign req_account  = req_q.account;
   assign req_dest     = req_q.dest;
   assign req_amount   = req_q.amount;
   assign disp_balance = disp_q;
   assign status       = status_q;
   assign key_err      = key_err_q;

endmodule

// File: tb/tb_atm_session_ctrl.sv
// Directed, table-driven bench for atm_session_ctrl: one vector per clock,
// every output compared after the edge that consumed the vector's inputs.
module tb_atm_session_ctrl;

   localparam int unsigned T = 1000;

   logic        clk = 1'b0;
   logic        rst;
   logic        key_valid;
   logic [3:0]  key_code;
   logic        req_valid;
   logic        req_ready;
   logic [1:0]  req_opt;
   logic [15:0] req_account;
   logic [15:0] req_dest;
   logic [9:0]  req_amount;
   logic        rsp_valid;
   logic        rsp_error;
   logic [9:0]  rsp_balance;
   logic [9:0]  disp_balance;
   logic [1:0]  status;
   logic        key_err;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic        kv;
      logic [3:0]  kc;
      logic        rdy, rv, re;
      logic [9:0]  rb;
      logic        e_rv;
      logic [1:0]  e_opt;
      logic [15:0] e_acc, e_dst;
      logic [9:0]  e_amt;
      logic [1:0]  e_st;
      logic        e_kerr;
      logic [9:0]  e_disp;
   } vec_t;

   vec_t tbl[$];

   atm_session_ctrl dut (
      .clk          (clk),
      .rst          (rst),
      .key_valid    (key_valid),
      .key_code     (key_code),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_opt      (req_opt),
      .req_account  (req_account),
      .req_dest     (req_dest),
      .req_amount   (req_amount),
      .rsp_valid    (rsp_valid),
      .rsp_error    (rsp_error),
      .rsp_balance  (rsp_balance),
      .disp_balance (disp_balance),
      .status       (status),
      .key_err      (key_err)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic vec_t v(input int kv, input int kc, input int rdy, input int rv,
                              input int re, input int rb, input int erv, input int eopt,
                              input int eacc, input int edst, input int eamt, input int est,
                              input int ekerr, input int edisp);
      vec_t x;
      x.kv = 1'(kv);     x.kc = 4'(kc);     x.rdy = 1'(rdy);  x.rv = 1'(rv);
      x.re = 1'(re);     x.rb = 10'(rb);    x.e_rv = 1'(erv); x.e_opt = 2'(eopt);
      x.e_acc = 16'(eacc); x.e_dst = 16'(edst); x.e_amt = 10'(eamt);
      x.e_st = 2'(est);  x.e_kerr = 1'(ekerr); x.e_disp = 10'(edisp);
      return x;
   endfunction

   task automatic chk(input string nm, input int idx, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s[%0d]: got %0d expected %0d", nm, idx, act, exp);
      end
   endtask

   task automatic apply(input vec_t x, input logic r);
      rst         = r;
      key_valid   = x.kv;
      key_code    = x.kc;
      req_ready   = x.rdy;
      rsp_valid   = x.rv;
      rsp_error   = x.re;
      rsp_balance = x.rb;
      @(posedge clk);
      #1;
   endtask

   task automatic check_all(input string tag, input int idx, input vec_t x);
      chk({tag, ".req_valid"},    idx, 32'(req_valid),    32'(x.e_rv));
      chk({tag, ".req_opt"},      idx, 32'(req_opt),      32'(x.e_opt));
      chk({tag, ".req_account"},  idx, 32'(req_account),  32'(x.e_acc));
      chk({tag, ".req_dest"},     idx, 32'(req_dest),     32'(x.e_dst));
      chk({tag, ".req_amount"},   idx, 32'(req_amount),   32'(x.e_amt));
      chk({tag, ".status"},       idx, 32'(status),       32'(x.e_st));
      chk({tag, ".key_err"},      idx, 32'(key_err),      32'(x.e_kerr));
      chk({tag, ".disp_balance"}, idx, 32'(disp_balance), 32'(x.e_disp));
   endtask

   task automatic key(input int kc);
      apply(v(1, kc, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
   endtask

   task automatic idle_cycle();
      apply(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
   endtask

   initial begin
      vec_t z;
      z = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      apply(z, 1'b1);
      apply(z, 1'b1);
      check_all("reset", 0, z);

      // Balance enquiry, account 1234, core stalls 5 cycles, balance 180
      tbl.push_back(v(1, 1,   0,0,0,0,   0,0,0,0,0,0,0,0));
      tbl.push_back(v(1, 2,   0,0,0,0,   0,0,0,0,0,0,0,0));
      tbl.push_back(v(1, 3,   0,0,0,0,   0,0,0,0,0,0,0,0));
      tbl.push_back(v(1, 4,   0,0,0,0,   0,0,0,0,0,0,0,0));
      tbl.push_back(v(1, 'hA, 0,0,0,0,   0,0,1234,0,0,0,0,0));
      tbl.push_back(v(1, 1,   0,0,0,0,   1,1,1234,0,0,1,0,0));
      tbl.push_back(v(0, 0,   0,0,0,0,   1,1,1234,0,0,1,0,0));
      tbl.push_back(v(0, 0,   0,0,0,0,   1,1,1234,0,0,1,0,0));
      tbl.push_back(v(0, 0,   0,0,0,0,   1,1,1234,0,0,1,0,0));
      tbl.push_back(v(1, 'hB, 0,0,0,0,   1,1,1234,0,0,1,0,0));
      tbl.push_back(v(0, 0,   0,0,0,0,   1,1,1234,0,0,1,0,0));
      tbl.push_back(v(0, 0,   1,1,0,999, 0,1,1234,0,0,1,0,0));
      tbl.push_back(v(0, 0,   0,0,0,0,   0,1,1234,0,0,1,0,0));
      tbl.push_back(v(0, 0,   0,1,0,180, 0,1,1234,0,0,2,0,180));
      tbl.push_back(v(0, 0,   0,0,0,0,   0,1,1234,0,0,2,0,180));
      tbl.push_back(v(1, 5,   0,0,0,0,   0,0,0,0,0,0,0,180));
      tbl.push_back(v(1, 'hA, 0,0,0,0,   0,0,0,0,0,0,0,180));
      // Account digit overflow, bad option, illegal key, cancel
      tbl.push_back(v(1, 1,   0,0,0,0,   0,0,0,0,0,0,0,180));
      tbl.push_back(v(1, 2,   0,0,0,0,   0,0,0,0,0,0,0,180));
      tbl.push_back(v(1, 3,   0,0,0,0,   0,0,0,0,0,0,0,180));
      tbl.push_back(v(1, 4,   0,0,0,0,   0,0,0,0,0,0,0,180));
      tbl.push_back(v(1, 5,   0,0,0,0,   0,0,0,0,0,0,1,180));
      tbl.push_back(v(1, 'hA, 0,0,0,0,   0,0,1234,0,0,0,0,180));
      tbl.push_back(v(1, 7,   0,0,0,0,   0,0,1234,0,0,0,1,180));
      tbl.push_back(v(1, 'hE, 0,0,0,0,   0,0,1234,0,0,0,1,180));
      tbl.push_back(v(1, 'hB, 0,0,0,0,   0,0,0,0,0,0,0,180));
      tbl.push_back(v(0, 0,   0,0,0,0,   0,0,0,0,0,0,0,180));
      // Transfer 2175 -> 6658, amount 100, core reports error
      tbl.push_back(v(1, 2,   0,0,0,0,   0,0,0,0,0,0,0,180));
      tbl.push_back(v(1, 1,   0,0,0,0,   0,0,0,0,0,0,0,180));
      tbl.push_back(v(1, 7,   0,0,0,0,   0,0,0,0,0,0,0,180));
      tbl.push_back(v(1, 5,   0,0,0,0,   0,0,0,0,0,0,0,180));
      tbl.push_back(v(1, 'hA, 0,0,0,0,   0,0,2175,0,0,0,0,180));
      tbl.push_back(v(1, 3,   0,0,0,0,   0,3,2175,0,0,0,0,180));
      tbl.push_back(v(1, 6,   0,0,0,0,   0,3,2175,0,0,0,0,180));
      tbl.push_back(v(1, 6,   0,0,0,0,   0,3,2175,0,0,0,0,180));
      tbl.push_back(v(1, 5,   0,0,0,0,   0,3,2175,0,0,0,0,180));
      tbl.push_back(v(1, 8,   0,0,0,0,   0,3,2175,0,0,0,0,180));
      tbl.push_back(v(1, 'hA, 0,0,0,0,   0,3,2175,6658,0,0,0,180));
      tbl.push_back(v(1, 1,   0,0,0,0,   0,3,2175,6658,0,0,0,180));
      tbl.push_back(v(1, 0,   0,0,0,0,   0,3,2175,6658,0,0,0,180));
      tbl.push_back(v(1, 0,   0,0,0,0,   0,3,2175,6658,0,0,0,180));
      tbl.push_back(v(1, 'hA, 0,0,0,0,   1,3,2175,6658,100,1,0,180));
      tbl.push_back(v(0, 0,   1,0,0,0,   0,3,2175,6658,100,1,0,180));
      tbl.push_back(v(0, 0,   0,0,0,0,   0,3,2175,6658,100,1,0,180));
      tbl.push_back(v(0, 0,   0,1,1,555, 0,3,2175,6658,100,3,0,180));
      tbl.push_back(v(1, 'hC, 0,0,0,0,   0,0,0,0,0,0,0,180));
      // Withdraw: clear, empty ENTER, illegal key, amount limit 1024 rejected
      tbl.push_back(v(1, 9,   0,0,0,0,   0,0,0,0,0,0,0,180));
      tbl.push_back(v(1, 'hA, 0,0,0,0,   0,0,9,0,0,0,0,180));
      tbl.push_back(v(1, 2,   0,0,0,0,   0,2,9,0,0,0,0,180));
      tbl.push_back(v(1, 5,   0,0,0,0,   0,2,9,0,0,0,0,180));
      tbl.push_back(v(1, 'hC, 0,0,0,0,   0,2,9,0,0,0,0,180));
      tbl.push_back(v(1, 'hA, 0,0,0,0,   0,2,9,0,0,0,1,180));
      tbl.push_back(v(1, 'hD, 0,0,0,0,   0,2,9,0,0,0,1,180));
      tbl.push_back(v(1, 1,   0,0,0,0,   0,2,9,0,0,0,0,180));
      tbl.push_back(v(1, 0,   0,0,0,0,   0,2,9,0,0,0,0,180));
      tbl.push_back(v(1, 2,   0,0,0,0,   0,2,9,0,0,0,0,180));
      tbl.push_back(v(1, 4,   0,0,0,0,   0,2,9,0,0,0,1,180));
      tbl.push_back(v(1, 'hA, 0,0,0,0,   1,2,9,0,102,1,0,180));
      tbl.push_back(v(0, 0,   1,0,0,0,   0,2,9,0,102,1,0,180));
      tbl.push_back(v(0, 0,   0,1,0,77,  0,2,9,0,102,2,0,180));
      tbl.push_back(v(1, 0,   0,0,0,0,   0,0,0,0,0,0,0,180));

      foreach (tbl[i]) begin
         apply(tbl[i], 1'b0);
         check_all("vec", i, tbl[i]);
      end

      // Timeout: exactly T cycles in WAIT_RSP without a response
      key(5); key('hA); key(1);
      apply(v(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
      repeat (T - 1) idle_cycle();
      chk("tmo.status_busy", 0, 32'(status), 32'd1);
      idle_cycle();
      chk("tmo.status_err", 0, 32'(status), 32'd3);
      chk("tmo.req_valid", 0, 32'(req_valid), 32'd0);
      chk("tmo.disp", 0, 32'(disp_balance), 32'd180);
      key('hA);
      chk("tmo.status_idle", 0, 32'(status), 32'd0);
      chk("tmo.account_clr", 0, 32'(req_account), 32'd0);

      // Response arriving in the expiry cycle wins over the timeout
      key(4); key('hA); key(1);
      apply(v(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
      repeat (T - 1) idle_cycle();
      apply(v(0, 0, 0, 1, 0, 321, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
      chk("tie.status_ok", 0, 32'(status), 32'd2);
      chk("tie.disp", 0, 32'(disp_balance), 32'd321);
      key(9);
      chk("tie.status_idle", 0, 32'(status), 32'd0);

      // Reset while waiting for a response; the late response is ignored
      key(6); key('hA); key(1);
      apply(v(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
      chk("rst.pre_busy", 0, 32'(status), 32'd1);
      apply(z, 1'b1);
      check_all("rst.in_wait", 0, z);
      apply(v(0, 0, 0, 1, 0, 999, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
      check_all("rst.late_rsp", 0, z);
      // Key coinciding with reset is dropped; ENTER in IDLE does nothing
      apply(v(1, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b1);
      key('hA);
      check_all("rst.key_drop", 0, z);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
